// File: rtl/sram_sp_wb_bridge.sv
// Purpose : Wishbone B3 slave that turns bus cycles into single-port SRAM accesses.
// Latency : a read is issued in the request cycle and acked one cycle later; a write commits in its ack cycle.
// Backpr. : a single access takes 2 clocks; a burst streams one beat per clock until cti=111 or req drops.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   wb_*_i / wb_*_o   Wishbone B3 slave (adr, dat, sel, we, cyc, stb, cti, bte / dat, ack, err)
//   sram_*            single-port SRAM initiator (ce, we, oe, addr, din, sel out; dout in, 1-cycle read latency)
//
// Build option: define OPTIMSOC_WB2SRAM_BURST_EN to compile incrementing and wrapping
// burst support. Without it every request is served as a classic single cycle.
module sram_sp_wb_bridge #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MEM_SIZE = 'h8000,
  localparam int SW      = DW / 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] wb_adr_i,
  input  logic [DW-1:0] wb_dat_i,
  input  logic [SW-1:0] wb_sel_i,
  input  logic          wb_we_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic [2:0]    wb_cti_i,
  input  logic [1:0]    wb_bte_i,
  output logic [DW-1:0] wb_dat_o,
  output logic          wb_ack_o,
  output logic          wb_err_o,
  output logic          sram_ce,
  output logic          sram_we,
  output logic          sram_oe,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_din,
  output logic [SW-1:0] sram_sel,
  input  logic [DW-1:0] sram_dout
);

  localparam logic [AW-1:0] MEM_LIMIT = AW'(MEM_SIZE);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SINGLE = 2'd1,
`ifdef OPTIMSOC_WB2SRAM_BURST_EN
    BURST  = 2'd2,
`endif
    ERR    = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cur_addr_q, cur_addr_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;

  logic req;
  logic adr_oor;

  assign req     = wb_cyc_i & wb_stb_i;
  assign adr_oor = (wb_adr_i >= MEM_LIMIT);

`ifdef OPTIMSOC_WB2SRAM_BURST_EN
  localparam int     SWL     = $clog2(SW);
  localparam logic [2:0] CTI_INC = 3'b010;

  logic [AW-1:0] cur_w, inc_w, wrap_mask, nxt_w, nxt_addr;
  logic          nxt_oor;

  // Next burst address: the bits selected by wrap_mask advance, the rest are held.
  // Linear bursts select every bit, so the whole word index increments.
  always_comb begin
    cur_w = cur_addr_q >> SWL;
    inc_w = cur_w + AW'(1);
    case (wb_bte_i)
      2'b01:   wrap_mask = AW'(3);
      2'b10:   wrap_mask = AW'(7);
      2'b11:   wrap_mask = AW'(15);
      default: wrap_mask = '1;
    endcase
    nxt_w    = (cur_w & ~wrap_mask) | (inc_w & wrap_mask);
    nxt_addr = nxt_w << SWL;
    nxt_oor  = (nxt_addr >= MEM_LIMIT);
  end
`else
  // Burst qualifiers are not interpreted in this build.
  logic unused_burst;
  assign unused_burst = ^{wb_cti_i, wb_bte_i};
`endif

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    sram_ce    = 1'b0;
    sram_we    = 1'b0;
    sram_oe    = 1'b0;
    sram_addr  = '0;
    sram_din   = '0;
    sram_sel   = '0;

    case (state_q)
      IDLE: begin
        if (req) begin
          if (adr_oor) begin
            state_d = ERR;
          end else begin
            cur_addr_d = wb_adr_i;
            // Reads go out immediately so data is ready in the ack cycle.
            if (!wb_we_i) begin
              sram_ce   = 1'b1;
              sram_oe   = 1'b1;
              sram_addr = wb_adr_i;
              sram_sel  = '1;
            end
`ifdef OPTIMSOC_WB2SRAM_BURST_EN
            state_d = (wb_cti_i == CTI_INC) ? BURST : SINGLE;
`else
            state_d = SINGLE;
`endif
          end
        end
      end

      SINGLE: begin
        if (req && wb_we_i) begin
          sram_ce   = 1'b1;
          sram_we   = 1'b1;
          sram_addr = cur_addr_q;
          sram_din  = wb_dat_i;
          sram_sel  = wb_sel_i;
        end
        // req is intentionally not re-sampled here: the master still holds the acked beat.
        state_d = IDLE;
      end

`ifdef OPTIMSOC_WB2SRAM_BURST_EN
      BURST: begin
        if (req && wb_we_i) begin
          sram_ce   = 1'b1;
          sram_we   = 1'b1;
          sram_addr = cur_addr_q;
          sram_din  = wb_dat_i;
          sram_sel  = wb_sel_i;
        end
        if (req && (wb_cti_i == CTI_INC)) begin
          if (nxt_oor) begin
            // The beat that would cross the end of memory is answered with err.
            state_d = ERR;
          end else begin
            cur_addr_d = nxt_addr;
            if (!wb_we_i) begin
              sram_ce   = 1'b1;
              sram_oe   = 1'b1;
              sram_addr = nxt_addr;
              sram_sel  = '1;
            end
          end
        end else begin
          // End of burst (cti=111) or master withdrew: the last ack is the one in flight.
          state_d = IDLE;
        end
      end
`endif

      ERR: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Reset cancels whatever access the current state would have launched.
    if (rst) begin
      sram_ce   = 1'b0;
      sram_we   = 1'b0;
      sram_oe   = 1'b0;
      sram_addr = '0;
      sram_din  = '0;
      sram_sel  = '0;
    end
  end

`ifdef OPTIMSOC_WB2SRAM_BURST_EN
  assign ack_d = (state_d == SINGLE) || (state_d == BURST);
`else
  assign ack_d = (state_d == SINGLE);
`endif
  assign err_d = (state_d == ERR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cur_addr_q <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign wb_dat_o = ack_q ? sram_dout : '0;

endmodule

// File: doc/sram_sp_wb_bridge.md
# sram_sp_wb_bridge

Wishbone B3 slave that acts as the initiator for a single-port SRAM (`sram_sp` port: ce/we/oe/addr/din/sel/dout) and translates bus cycles into SRAM accesses. It sits between a tile's Wishbone bus and its local memory, and supports classic single cycles and incrementing or wrapping bursts. Reads issue one cycle ahead of the acknowledge. Writes commit in the acknowledge cycle.

## Interface
- `AW`, 32, byte address width on both sides
- `DW`, 32, data width (32, 16 or 8); `SW = DW/8` byte selects
- `MEM_SIZE`, 'h8000, memory size in bytes; accesses at `adr >= MEM_SIZE` receive an error

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `wb_adr_i`  in  AW  byte address
- `wb_dat_i`  in  DW  write data
- `wb_sel_i`  in  SW  byte selects
- `wb_we_i`  in  1  write enable
- `wb_cyc_i`, `wb_stb_i`  in  1  cycle and strobe
- `wb_cti_i`  in  3  cycle type: 000 classic, 010 incrementing burst, 111 end of burst
- `wb_bte_i`  in  2  burst type: 00 linear, 01 wrap-4, 10 wrap-8, 11 wrap-16
- `wb_dat_o`  out  DW  read data
- `wb_ack_o`, `wb_err_o`  out  1  acknowledge and error (both registered)
- `sram_ce`, `sram_we`, `sram_oe`  out  1  SRAM chip enable, write enable, output enable
- `sram_addr`  out  AW  SRAM byte address
- `sram_din`  out  DW  SRAM write data
- `sram_sel`  out  SW  SRAM byte selects
- `sram_dout`  in  DW  SRAM read data, valid one cycle after a read access

## Operation
- **States:** IDLE, SINGLE, BURST, ERR.
- **Request:** `req = wb_cyc_i & wb_stb_i`.
- **IDLE with `req`:**
  - If `wb_adr_i >= MEM_SIZE`: go to ERR. `wb_err_o=1` next cycle. No SRAM access.
  - Read: same cycle, drive `sram_ce=1`, `sram_oe=1`, `sram_addr=wb_adr_i`.
  - Latch the address in `cur_addr`.
  - Go to BURST if `wb_cti_i==010`, else SINGLE. `wb_ack_o=1` next cycle.
- **SINGLE (ack cycle):**
  - Writes commit here: `sram_ce=1`, `sram_we=1`, `sram_addr=cur_addr`, `sram_din=wb_dat_i`, `sram_sel=wb_sel_i`.
  - Return to IDLE. `req` is not sampled as a new request in this cycle.
- **BURST (ack cycle):**
  - Writes commit at `cur_addr` as in SINGLE.
  - If `req` and `wb_cti_i==010`: compute `nxt_addr`, stay in BURST, keep ack high. A read also issues at `nxt_addr` in this cycle.
  - If `wb_cti_i==111`: the current beat completes, no further access, return to IDLE.
  - If `req` drops: ack deasserts next cycle, return to IDLE. Any speculative read is discarded.
- **Burst address arithmetic:**
  - Word index `w = cur_addr >> log2(SW)`.
  - Linear: `w+1`.
  - wrap-N: the low `log2(N)` bits of `w` increment modulo N; the upper bits are held.
  - If a linear burst address reaches `MEM_SIZE`: that beat gets `wb_err_o` instead of ack, and the burst ends.
- **Data and selects:**
  - `wb_dat_o = sram_dout` while `wb_ack_o`, else 0.
  - SRAM reads use `sram_sel` = all ones.
- **Reset:** `rst` in any state aborts the current transfer, returns to IDLE, and discards the pending access.

## Timing
- **Reset values:** `wb_ack_o=0`, `wb_err_o=0`, `wb_dat_o=0`, `sram_ce=0`, `sram_we=0`, `sram_oe=0`, `sram_addr=0`, `sram_din=0`, `sram_sel=0`.
- **Single access:** request cycle t, ack at t+1, earliest next request at t+2 (2 cycles per access).
- **Burst:** ack at t+1 through t+N, one beat per cycle. For reads, the SRAM read for beat k+1 issues in the ack cycle of beat k.
- **Error:** ack and err are never high together. Err is high for exactly one cycle.
- **SRAM outputs:** combinational from state, `cur_addr` and the Wishbone inputs. No combinational path from `sram_dout` to any control output.

## Configuration
- `OPTIMSOC_WB2SRAM_BURST_EN` defined: burst behaviour as above.
- `OPTIMSOC_WB2SRAM_BURST_EN` undefined:
  - `wb_cti_i` and `wb_bte_i` are ignored and every request uses SINGLE.
  - A master issuing `cti=010` is served at 2 cycles per beat.
  - The BURST state and wrap logic are not compiled.

## Test plan
- Single write `adr=0x10`, `dat=0xDEADBEEF`, `sel=0xF` -> `sram_we=1`, `sram_addr=0x10` at t+1 with ack. A single read of 0x10 then returns 0xDEADBEEF with ack at t+1.
- Byte write `sel=0x2`, `dat=0x0000AB00` onto 0x11223344 at 0x20 -> read returns 0x1122AB44.
- Wrap-4 read burst starting at 0x18 -> SRAM read addresses 0x18, 0x1C, 0x10, 0x14, four consecutive acks. `cti=111` on the last beat -> ack low the next cycle.
- Linear 8-beat write burst at 0x100 -> 8 consecutive ack cycles, writes at 0x100 through 0x11C. With the macro undefined -> 16 cycles, ack every other cycle.
- Read at `adr=MEM_SIZE` -> `wb_err_o` for one cycle, no ack, `sram_ce` stays 0.
- `rst` asserted mid-burst on beat 2 -> next cycle ack=0, IDLE, no further SRAM access. A new single read then completes normally.
